bus_mmio_router: RTL and testbench
==================================

# bus_mmio_router

Parametrised MMIO sub-bus router between the main bus master port and `NSLAVE` peripheral slave ports, each owning one equal-sized address window. It decodes, forwards and buffers single-beat command, write-data and read-data transfers one transaction at a time. It answers unmapped addresses itself with a bus error instead of stalling. It optionally aborts transactions to unresponsive slaves with a timeout error.

## Interface
- `NSLAVE`, 4, number of slave ports (1..16).
- `WIN_BITS`, 6, word-address bits per slave window; slave index is `bmain_addr[WIN_BITS+5:WIN_BITS+2]`.
- `TIMEOUT`, 255, cycles a slave may stall a transaction before abort (used only with `BUS_MMIO_TIMEOUT_EN`).
- `clk_core` in 1: clock.
- `reset_n` in 1: asynchronous, active-low reset.
- `bmain_cvalid_bmmio` in 1 / `bmmio_cready` out 1 / `bmain_cmd` in 1 (1=read) / `bmain_addr` in [WIN_BITS+5:2]: master command channel.
- `bmain_wvalid_bmmio` in 1 / `bmmio_wready` out 1 / `bmain_wdata` in 32: master write data.
- `bmmio_rvalid` out 1 / `bmain_rready_bmmio` in 1 / `bmmio_rdata` out 32: master read data.
- `bmmio_error` out 1 / `bmain_eack_bmmio` in 1: error level and acknowledge.
- `bmmio_cmd` out 1, `bmmio_addr` out [WIN_BITS+1:2], `bmmio_wdata` out 32: common to all slaves.
- `bmmio_cvalid` out NSLAVE / `slv_cready` in NSLAVE: per-slave command handshake.
- `bmmio_wvalid` out NSLAVE / `slv_wready` in NSLAVE: per-slave write handshake.
- `slv_rvalid` in NSLAVE / `bmmio_rready` out NSLAVE / `slv_rdata` in 32*NSLAVE (slave i at [32i+31:32i]): per-slave read.
- `slv_error` in NSLAVE / `bmmio_eack` out NSLAVE: per-slave error and acknowledge.

## Operation
- Registers: state, `cmd`, `addr`, `idx`, 1-entry write buffer (`wvalid_q`, `wdata_q`), 1-entry read buffer (`rvalid_q`, `rdata_q`), `drained`, timeout counter.
- **IDLE**
  - `bmmio_cready`=1.
  - On command beat: latch `cmd`, `addr`, and `idx`.
  - If `idx` < NSLAVE, go to SEND.
  - Otherwise go to ERR with `drained` = `cmd`.
- **SEND**
  - `bmmio_cvalid[idx]`=1.
  - On `slv_cready[idx]`: go to RD if `cmd`, else WR.
- **WR**
  - `bmmio_wvalid[idx]` = `wvalid_q`.
  - On `slv_wready[idx]` beat: buffer empties and state goes to IDLE.
- **RD**
  - `bmmio_rready[idx]` = ~`rvalid_q` | master read beat.
  - On slave beat: capture `slv_rdata` slice, set `rvalid_q`, go to IDLE.
- **ERR**
  - Internal error flag = 1.
  - For a write: discard one buffered wdata beat, then set `drained`.
  - Leave for IDLE on `bmain_eack_bmmio` & `drained`.
- Write buffer:
  - `bmmio_wready` = ~`wvalid_q` | outgoing beat.
  - Fills independently of state, so wdata may precede or follow the command.
- Read buffer:
  - `bmmio_rvalid` = `rvalid_q`.
  - Clears on master beat.
  - A new command may start while it is full; the next read's `rready` waits for it to empty.
- `bmmio_error` = |`slv_error` | internal error flag.
- `bmmio_eack` = {NSLAVE{`bmain_eack_bmmio`}}.
- All per-slave outputs are zero for non-selected slaves.
- `bmmio_addr` = `addr[WIN_BITS+1:2]`.

## Timing
- Reset (async, immediate):
  - state=IDLE; `wvalid_q`=`rvalid_q`=0; counter=0.
  - Outputs: `bmmio_cready`=1, `bmmio_wready`=1, all other outputs 0.
  - `wdata_q`/`rdata_q` are unreset.
  - Reset mid-transaction drops it silently.
- Command beat at cycle 0 → `bmmio_cvalid[idx]` high at cycle 1.
- Read latency:
  - Slave read beat at cycle k → `bmmio_rvalid` at k+1.
  - `bmmio_rdata` is stable until the master beat.
- Write: slave `wvalid` rises in the cycle after both WR entry and `wvalid_q`=1 hold.
- Next `bmmio_cready`: the cycle after the slave write/read beat.
- Simultaneous master read beat and slave read beat: the buffer refills; `rvalid_q` stays 1 with the new data.
- Simultaneous incoming and outgoing write beat: the buffer reloads.
- Slave error during a transaction does not change state; the master handles it via eack.

## Configuration
- `BUS_MMIO_TIMEOUT_EN` defined:
  - Counter runs in SEND/WR/RD and clears on state change.
  - Reaching `TIMEOUT` forces ERR; the slave's valid/ready drops the same cycle.
  - For an aborted write, `drained` = ~`wvalid_q` if the write was already dropped, else a buffered beat is discarded.
- Undefined:
  - No counter.
  - Stalled slaves stall the router indefinitely.
  - `TIMEOUT` is unused.

## Test plan
- Read: NSLAVE=4, read addr 0x104 (word 0x41), slave 1 returns 0xDEADBEEF after 3 cycles → only `bmmio_cvalid[1]` set; `bmmio_addr`=0x01; `bmmio_rdata`=0xDEADBEEF one cycle after the slave beat.
- Early wdata: write 0x12345678 to 0x300 with wdata presented 2 cycles before the command → slave 3 sees `bmmio_wvalid[3]` with `bmmio_wdata`=0x12345678; `bmmio_cready` high again the next cycle.
- Unmapped read: NSLAVE=3, read 0x300 → `bmmio_error`=1, no slave `cvalid`; stays until eack, then IDLE.
- Unmapped write: NSLAVE=3, write 0x300 → `bmmio_error`=1, the wdata beat is consumed, no slave `cvalid`; IDLE after eack.
- Master backpressure: hold `bain_rready_bmmio`=0 with `rvalid_q`=1, issue a second read → second slave's `rready` stays 0 until the first master beat; both data words are delivered in order.
- Timeout: with `BUS_MMIO_TIMEOUT_EN` and TIMEOUT=8, slave 2 never asserts `cready` → `bmmio_cvalid[2]` drops and `bmmio_error` rises 8 cycles after SEND entry; eack returns to IDLE.

Source files
------------

// File: rtl/bus_mmio_router.sv
// MMIO sub-bus router: decodes one master transaction at a time onto
// NSLAVE equal address windows, buffers wdata/rdata, errors unmapped.
// Ports: bmain_* master side, bmmio_* router outputs, slv_* slave inputs.
// Optional slave timeout abort: define BUS_MMIO_TIMEOUT_EN.
module bus_mmio_router #(
  parameter int NSLAVE   = 4,
  parameter int WIN_BITS = 6,
  parameter int TIMEOUT  = 255
) (
  input  logic                   clk_core,
  input  logic                   reset_n,
  input  logic                   bmain_cvalid_bmmio,
  output logic                   bmmio_cready,
  input  logic                   bmain_cmd,
  input  logic [WIN_BITS+5:2]    bmain_addr,
  input  logic                   bmain_wvalid_bmmio,
  output logic                   bmmio_wready,
  input  logic [31:0]            bmain_wdata,
  output logic                   bmmio_rvalid,
  input  logic                   bmain_rready_bmmio,
  output logic [31:0]            bmmio_rdata,
  output logic                   bmmio_error,
  input  logic                   bmain_eack_bmmio,
  output logic                   bmmio_cmd,
  output logic [WIN_BITS+1:2]    bmmio_addr,
  output logic [31:0]            bmmio_wdata,
  output logic [NSLAVE-1:0]      bmmio_cvalid,
  input  logic [NSLAVE-1:0]      slv_cready,
  output logic [NSLAVE-1:0]      bmmio_wvalid,
  input  logic [NSLAVE-1:0]      slv_wready,
  input  logic [NSLAVE-1:0]      slv_rvalid,
  output logic [NSLAVE-1:0]      bmmio_rready,
  input  logic [32*NSLAVE-1:0]   slv_rdata,
  input  logic [NSLAVE-1:0]      slv_error,
  output logic [NSLAVE-1:0]      bmmio_eack
);

  if (NSLAVE < 1 || NSLAVE > 16 || TIMEOUT < 1) begin : g_param_chk
    $error("bus_mmio_router: parameter out of range");
  end

  localparam logic [2:0] IDLE = 3'd0;
  localparam logic [2:0] SEND = 3'd1;
  localparam logic [2:0] WR   = 3'd2;
  localparam logic [2:0] RD   = 3'd3;
  localparam logic [2:0] ERR  = 3'd4;

  logic [2:0]          r_state;
  logic [2:0]          w_nstate;
  logic                r_cmd;
  logic [WIN_BITS+1:2] r_addr;
  logic [3:0]          r_idx;
  logic                r_wvalid;
  logic [31:0]         r_wdata;
  logic                r_rvalid;
  logic [31:0]         r_rdata;
  logic                r_drained;

  logic [3:0]          w_cidx;
  logic                w_map;
  logic [NSLAVE-1:0]   w_sel;
  logic [31:0]         w_slv_rd;
  logic                w_tout;
  logic                w_rd_go;
  logic                w_cbeat;
  logic                w_wbeat;
  logic                w_rbeat;
  logic                w_mbeat;
  logic                w_win;
  logic                w_wdisc;
  logic                w_wout;

  assign w_cidx = bmain_addr[WIN_BITS+5:WIN_BITS+2];
  assign w_map  = {1'b0, w_cidx} < 5'(NSLAVE);

  always_comb begin
    w_sel    = '0;
    w_slv_rd = '0;
    for (int i = 0; i < NSLAVE; i++) begin
      w_sel[i] = (r_idx == 4'(i));
      w_slv_rd = w_slv_rd | (slv_rdata[32*i +: 32] & {32{w_sel[i]}});
    end
  end

`ifdef BUS_MMIO_TIMEOUT_EN
  localparam int TW = (TIMEOUT < 2) ? 1 : $clog2(TIMEOUT + 1);
  logic [TW-1:0] r_tcnt;
  logic          w_busy;

  assign w_busy = (r_state == SEND) || (r_state == WR) || (r_state == RD);
  assign w_tout = w_busy && (r_tcnt == TW'(TIMEOUT));

  // Counts cycles spent in one busy state; restarts on any transition.
  always_ff @(posedge clk_core or negedge reset_n) begin
    if (!reset_n) begin
      r_tcnt <= '0;
    end else if (w_nstate != r_state || !w_busy) begin
      r_tcnt <= '0;
    end else begin
      r_tcnt <= r_tcnt + 1'b1;
    end
  end
`else
  assign w_tout = 1'b0;
`endif

  assign w_mbeat = r_rvalid & bmain_rready_bmmio;
  assign w_rd_go = ~r_rvalid | w_mbeat;

  assign bmmio_cvalid = (r_state == SEND && !w_tout) ? w_sel : '0;
  assign bmmio_wvalid = (r_state == WR && r_wvalid && !w_tout) ? w_sel : '0;
  assign bmmio_rready = (r_state == RD && w_rd_go && !w_tout) ? w_sel : '0;

  assign w_cbeat = |(bmmio_cvalid & slv_cready);
  assign w_wbeat = |(bmmio_wvalid & slv_wready);
  assign w_rbeat = |(bmmio_rready & slv_rvalid);

  // An errored write swallows exactly one wdata beat so the master's
  // data stream stays aligned with its commands.
  assign w_wdisc = (r_state == ERR) && !r_drained && r_wvalid;
  assign w_wout  = w_wbeat | w_wdisc;
  assign w_win   = bmain_wvalid_bmmio & bmmio_wready;

  assign bmmio_cready = (r_state == IDLE);
  assign bmmio_wready = ~r_wvalid | w_wout;
  assign bmmio_rvalid = r_rvalid;
  assign bmmio_rdata  = r_rvalid ? r_rdata : 32'd0;
  assign bmmio_wdata  = r_wvalid ? r_wdata : 32'd0;
  assign bmmio_cmd    = r_cmd;
  assign bmmio_addr   = r_addr;
  assign bmmio_error  = (|slv_error) | (r_state == ERR) | w_tout;
  assign bmmio_eack   = {NSLAVE{bmain_eack_bmmio}};

  always_comb begin
    w_nstate = r_state;
    unique case (r_state)
      IDLE: if (bmain_cvalid_bmmio) w_nstate = w_map ? SEND : ERR;
      SEND: if (w_cbeat) w_nstate = r_cmd ? RD : WR;
      WR:   if (w_wbeat) w_nstate = IDLE;
      RD:   if (w_rbeat) w_nstate = IDLE;
      ERR:  if (bmain_eack_bmmio && r_drained) w_nstate = IDLE;
      default: w_nstate = IDLE;
    endcase
    if (w_tout) w_nstate = ERR;
  end

  always_ff @(posedge clk_core or negedge reset_n) begin
    if (!reset_n) begin
      r_state   <= IDLE;
      r_cmd     <= 1'b0;
      r_addr    <= '0;
      r_idx     <= '0;
      r_drained <= 1'b0;
      r_wvalid  <= 1'b0;
      r_rvalid  <= 1'b0;
    end else begin
      r_state <= w_nstate;
      if (r_state == IDLE && bmain_cvalid_bmmio) begin
        r_cmd     <= bmain_cmd;
        r_addr    <= bmain_addr[WIN_BITS+1:2];
        r_idx     <= w_cidx;
        r_drained <= bmain_cmd;
      end else if (w_tout) begin
        r_drained <= r_cmd | ~r_wvalid;
      end else if (w_wdisc) begin
        r_drained <= 1'b1;
      end
      if (w_win) begin
        r_wvalid <= 1'b1;
      end else if (w_wout) begin
        r_wvalid <= 1'b0;
      end
      if (w_rbeat) begin
        r_rvalid <= 1'b1;
      end else if (w_mbeat) begin
        r_rvalid <= 1'b0;
      end
    end
  end

  // Data registers carry no reset; their valid flags qualify them.
  always_ff @(posedge clk_core) begin
    if (w_win) r_wdata <= bmain_wdata;
    if (w_rbeat) r_rdata <= w_slv_rd;
  end

endmodule

// File: tb/tb_bus_mmio_router.sv
// Directed self-checking bench for bus_mmio_router (NSLAVE=4).
// Timeout scenario is compiled only with BUS_MMIO_TIMEOUT_EN.
module tb_bus_mmio_router;

  logic         clk_core = 1'b0;
  logic         reset_n;
  logic         cv, cmd, wv, rr, eack;
  logic [11:2]  addr;
  logic [31:0]  wd;
  logic         o_cready, o_wready, o_rvalid, o_error, o_cmd;
  logic [31:0]  o_rdata, o_wdata;
  logic [7:2]   o_addr;
  logic [3:0]   o_cvalid, o_wvalid, o_rready, o_eack;
  logic [3:0]   s_cready, s_wready, s_rvalid, s_error;
  logic [127:0] s_rdata;

  int checks = 0;
  int errors = 0;

  always #5 clk_core = ~clk_core;

  bus_mmio_router #(.NSLAVE(4), .WIN_BITS(6), .TIMEOUT(8)) dut (
    .clk_core(clk_core), .reset_n(reset_n),
    .bmain_cvalid_bmmio(cv), .bmmio_cready(o_cready),
    .bmain_cmd(cmd), .bmain_addr(addr),
    .bmain_wvalid_bmmio(wv), .bmmio_wready(o_wready),
    .bmain_wdata(wd),
    .bmmio_rvalid(o_rvalid), .bmain_rready_bmmio(rr),
    .bmmio_rdata(o_rdata),
    .bmmio_error(o_error), .bmain_eack_bmmio(eack),
    .bmmio_cmd(o_cmd), .bmmio_addr(o_addr), .bmmio_wdata(o_wdata),
    .bmmio_cvalid(o_cvalid), .slv_cready(s_cready),
    .bmmio_wvalid(o_wvalid), .slv_wready(s_wready),
    .slv_rvalid(s_rvalid), .bmmio_rready(o_rready),
    .slv_rdata(s_rdata),
    .slv_error(s_error), .bmmio_eack(o_eack)
  );

  task automatic step();
    @(posedge clk_core);
    #1;
  endtask

  task automatic settle();
    @(negedge clk_core);
  endtask

  task automatic test_reset();
    reset_n = 1'b0;
    cv = 0; cmd = 0; wv = 0; rr = 0; eack = 0;
    addr = '0; wd = '0;
    s_cready = '0; s_wready = '0; s_rvalid = '0; s_error = '0;
    s_rdata = '0;
    #12;
    checks++;
    if (o_cready !== 1'b1 || o_wready !== 1'b1) begin
      errors++;
      $display("FAIL rst_ready got c=%b w=%b exp 1 1", o_cready, o_wready);
    end
    checks++;
    if ({o_cvalid, o_wvalid, o_rready, o_eack} !== 16'h0) begin
      errors++;
      $display("FAIL rst_slv got %h exp 0",
               {o_cvalid, o_wvalid, o_rready, o_eack});
    end
    checks++;
    if ({o_rvalid, o_error, o_cmd, o_addr, o_rdata, o_wdata} !== '0) begin
      errors++;
      $display("FAIL rst_misc got rv=%b er=%b rd=%h wd=%h exp 0",
               o_rvalid, o_error, o_rdata, o_wdata);
    end
    step();
    reset_n = 1'b1;
    step();
  endtask

  task automatic test_read();
    cv = 1; cmd = 1; addr = 10'h041;
    step();
    cv = 0;
    settle();
    checks++;
    if (o_cvalid !== 4'b0010 || o_addr !== 6'h01 || o_cmd !== 1'b1) begin
      errors++;
      $display("FAIL rd_send got cv=%b a=%h c=%b exp 0010 01 1",
               o_cvalid, o_addr, o_cmd);
    end
    step();
    step();
    s_cready = 4'b0010;
    step();
    s_cready = 4'b0000;
    settle();
    checks++;
    if (o_rready !== 4'b0010 || o_rvalid !== 1'b0) begin
      errors++;
      $display("FAIL rd_rready got rr=%b rv=%b exp 0010 0",
               o_rready, o_rvalid);
    end
    step();
    step();
    s_rvalid = 4'b0010;
    s_rdata[63:32] = 32'hDEADBEEF;
    step();
    s_rvalid = 4'b0000;
    s_rdata = '0;
    settle();
    checks++;
    if (o_rvalid !== 1'b1 || o_rdata !== 32'hDEADBEEF ||
        o_cready !== 1'b1 || o_rready !== 4'b0) begin
      errors++;
      $display("FAIL rd_data got rv=%b d=%h cr=%b exp 1 deadbeef 1",
               o_rvalid, o_rdata, o_cready);
    end
    rr = 1;
    step();
    rr = 0;
    settle();
    checks++;
    if (o_rvalid !== 1'b0) begin
      errors++;
      $display("FAIL rd_drain got %b exp 0", o_rvalid);
    end
  endtask

  task automatic test_early_wdata();
    step();
    wv = 1; wd = 32'h12345678;
    settle();
    checks++;
    if (o_wready !== 1'b1) begin
      errors++;
      $display("FAIL wr_wready0 got %b exp 1", o_wready);
    end
    step();
    wv = 0;
    settle();
    checks++;
    if (o_wready !== 1'b0) begin
      errors++;
      $display("FAIL wr_full got %b exp 0", o_wready);
    end
    step();
    cv = 1; cmd = 0; addr = 10'h0C0;
    step();
    cv = 0;
    s_cready = 4'b1000;
    settle();
    checks++;
    if (o_cvalid !== 4'b1000 || o_wvalid !== 4'b0) begin
      errors++;
      $display("FAIL wr_send got cv=%b wv=%b exp 1000 0000",
               o_cvalid, o_wvalid);
    end
    step();
    s_cready = 4'b0;
    s_wready = 4'b1000;
    settle();
    checks++;
    if (o_wvalid !== 4'b1000 || o_wdata !== 32'h12345678 ||
        o_wready !== 1'b1) begin
      errors++;
      $display("FAIL wr_beat got wv=%b d=%h wr=%b exp 1000 12345678 1",
               o_wvalid, o_wdata, o_wready);
    end
    step();
    s_wready = 4'b0;
    settle();
    checks++;
    if (o_cready !== 1'b1 || o_wvalid !== 4'b0) begin
      errors++;
      $display("FAIL wr_done got cr=%b wv=%b exp 1 0000",
               o_cready, o_wvalid);
    end
  endtask

  task automatic test_unmapped_read();
    cv = 1; cmd = 1; addr = 10'h140;
    step();
    cv = 0;
    settle();
    checks++;
    if (o_error !== 1'b1 || o_cvalid !== 4'b0 || o_cready !== 1'b0) begin
      errors++;
      $display("FAIL ur_err got e=%b cv=%b cr=%b exp 1 0000 0",
               o_error, o_cvalid, o_cready);
    end
    step();
    eack = 1;
    settle();
    checks++;
    if (o_error !== 1'b1 || o_eack !== 4'b1111) begin
      errors++;
      $display("FAIL ur_hold got e=%b ea=%b exp 1 1111", o_error, o_eack);
    end
    step();
    eack = 0;
    settle();
    checks++;
    if (o_error !== 1'b0 || o_cready !== 1'b1) begin
      errors++;
      $display("FAIL ur_idle got e=%b cr=%b exp 0 1", o_error, o_cready);
    end
  endtask

  task automatic test_unmapped_write();
    cv = 1; cmd = 0; addr = 10'h1C0;
    wv = 1; wd = 32'hA5A5A5A5;
    step();
    cv = 0; wv = 0;
    eack = 1;
    settle();
    checks++;
    if (o_error !== 1'b1 || o_cvalid !== 4'b0 || o_wready !== 1'b1) begin
      errors++;
      $display("FAIL uw_err got e=%b cv=%b wr=%b exp 1 0000 1",
               o_error, o_cvalid, o_wready);
    end
    step();
    settle();
    checks++;
    if (o_error !== 1'b1 || o_cready !== 1'b0) begin
      errors++;
      $display("FAIL uw_drain got e=%b cr=%b exp 1 0", o_error, o_cready);
    end
    step();
    eack = 0;
    settle();
    checks++;
    if (o_error !== 1'b0 || o_cready !== 1'b1 || o_wready !== 1'b1 ||
        o_wvalid !== 4'b0) begin
      errors++;
      $display("FAIL uw_idle got e=%b cr=%b wr=%b exp 0 1 1",
               o_error, o_cready, o_wready);
    end
  endtask

  task automatic test_back_to_back();
    cv = 1; cmd = 1; addr = 10'h004;
    step();
    cv = 0;
    s_cready = 4'b0001;
    step();
    s_cready = 4'b0;
    s_rvalid = 4'b0001;
    s_rdata[31:0] = 32'h11111111;
    step();
    s_rvalid = 4'b0;
    s_rdata = '0;
    cv = 1; addr = 10'h082;
    settle();
    checks++;
    if (o_rvalid !== 1'b1 || o_rdata !== 32'h11111111 ||
        o_cready !== 1'b1) begin
      errors++;
      $display("FAIL bb_first got rv=%b d=%h cr=%b exp 1 11111111 1",
               o_rvalid, o_rdata, o_cready);
    end
    step();
    cv = 0;
    s_cready = 4'b0100;
    step();
    s_cready = 4'b0;
    s_rvalid = 4'b0100;
    s_rdata[95:64] = 32'h22222222;
    settle();
    checks++;
    if (o_rready !== 4'b0) begin
      errors++;
      $display("FAIL bb_block got %b exp 0000", o_rready);
    end
    step();
    settle();
    checks++;
    if (o_rready !== 4'b0 || o_rdata !== 32'h11111111) begin
      errors++;
      $display("FAIL bb_hold got rr=%b d=%h exp 0000 11111111",
               o_rready, o_rdata);
    end
    step();
    rr = 1;
    settle();
    checks++;
    if (o_rready !== 4'b0100 || o_rdata !== 32'h11111111) begin
      errors++;
      $display("FAIL bb_open got rr=%b d=%h exp 0100 11111111",
               o_rready, o_rdata);
    end
    step();
    rr = 0;
    s_rvalid = 4'b0;
    s_rdata = '0;
    settle();
    checks++;
    if (o_rvalid !== 1'b1 || o_rdata !== 32'h22222222) begin
      errors++;
      $display("FAIL bb_second got rv=%b d=%h exp 1 22222222",
               o_rvalid, o_rdata);
    end
    rr = 1;
    step();
    rr = 0;
    settle();
    checks++;
    if (o_rvalid !== 1'b0 || o_cready !== 1'b1) begin
      errors++;
      $display("FAIL bb_empty got rv=%b cr=%b exp 0 1", o_rvalid, o_cready);
    end
  endtask

  task automatic test_slave_error();
    step();
    s_error = 4'b0100;
    settle();
    checks++;
    if (o_error !== 1'b1 || o_cready !== 1'b1) begin
      errors++;
      $display("FAIL se_pass got e=%b cr=%b exp 1 1", o_error, o_cready);
    end
    step();
    s_error = 4'b0;
    settle();
    checks++;
    if (o_error !== 1'b0) begin
      errors++;
      $display("FAIL se_clear got %b exp 0", o_error);
    end
  endtask

  task automatic test_timeout();
    cv = 1; cmd = 1; addr = 10'h080;
    step();
    cv = 0;
    for (int k = 0; k < 8; k++) begin
      settle();
      checks++;
      if (o_cvalid !== 4'b0100 || o_error !== 1'b0) begin
        errors++;
        $display("FAIL to_wait%0d got cv=%b e=%b exp 0100 0",
                 k, o_cvalid, o_error);
      end
      step();
    end
    settle();
    checks++;
    if (o_cvalid !== 4'b0 || o_error !== 1'b1) begin
      errors++;
      $display("FAIL to_abort got cv=%b e=%b exp 0000 1", o_cvalid, o_error);
    end
    step();
    eack = 1;
    step();
    eack = 0;
    settle();
    checks++;
    if (o_cready !== 1'b1 || o_error !== 1'b0) begin
      errors++;
      $display("FAIL to_idle got cr=%b e=%b exp 1 0", o_cready, o_error);
    end
  endtask

  task automatic test_reset_mid();
    cv = 1; cmd = 1; addr = 10'h041;
    step();
    cv = 0;
    #2;
    reset_n = 1'b0;
    #1;
    checks++;
    if (o_cvalid !== 4'b0 || o_cready !== 1'b1) begin
      errors++;
      $display("FAIL rm_drop got cv=%b cr=%b exp 0000 1",
               o_cvalid, o_cready);
    end
    step();
    reset_n = 1'b1;
    step();
  endtask

  initial begin
    test_reset();
    test_read();
    test_early_wdata();
    test_unmapped_read();
    test_unmapped_write();
    test_back_to_back();
    test_slave_error();
`ifdef BUS_MMIO_TIMEOUT_EN
    test_timeout();
`endif
    test_reset_mid();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
